// File: rtl/core_interface_regs_if.sv
// ----------------------------------------------------------------------------
// core_interface_regs_if
//
// Host instruction bus for the core_interface_regs register bridge.
//
// Signals:
//   instruction_i  8-bit opcode, presented every cycle
//   address_i      24-bit target address
//   value_i        32-bit write data
//   result_o       32-bit registered read result returned by the bridge
//
// Modports:
//   master  host side: drives instruction/address/value, receives result
//   slave   bridge side: receives instruction/address/value, drives result
// ----------------------------------------------------------------------------
interface core_interface_regs_if;
    logic [7:0]  instruction_i;
    logic [23:0] address_i;
    logic [31:0] value_i;
    logic [31:0] result_o;

    modport master (
        output instruction_i,
        output address_i,
        output value_i,
        input  result_o
    );

    modport slave (
        input  instruction_i,
        input  address_i,
        input  value_i,
        output result_o
    );
endinterface

// File: rtl/core_interface_regs.sv
// ----------------------------------------------------------------------------
// core_interface_regs
//
// Memory-mapped register bridge between a host instruction bus and one user
// core. Each cycle one 8-bit instruction is decoded against a 24-bit address
// window [START_ADDRESS, END_ADDRESS]. Inside the window, local index
// idx = address - START_ADDRESS selects:
//   0 .. TOTAL_INPUTS-1                           host-writable input regs
//   TOTAL_INPUTS .. TOTAL_INPUTS+TOTAL_OUTPUTS-1  read-only output regs
//   anything else                                 unmapped (reads 0)
//
// Opcodes: 0x00 NOP, 0x01 WRITE, 0x02 READ, 0x03 STREAM, 0x04 CLEAR,
//          0x05..0xFF behave as NOP.
//
// Optional feature macro: CORE_INTERFACE_STREAM_EN
//   defined     -> stream pointer, STREAM opcode and stream_o mirror exist
//   not defined -> stream_o is constant 0 and 0x03 decodes as NOP
//
// Ports:
//   clk_i           single clock, rising edge
//   rst_ni          synchronous active-low reset
//   host            host instruction bus (slave modport)
//   stream_o        registered mirror of the register at the stream pointer
//   core_inputs_o   flattened input regs, reg k at [32k+31:32k]
//   core_outputs_i  flattened core results, same packing
// ----------------------------------------------------------------------------
module core_interface_regs #(
    parameter int unsigned TOTAL_INPUTS  = 4,
    parameter int unsigned TOTAL_OUTPUTS = 1,
    parameter logic [23:0] START_ADDRESS = 24'd0,
    parameter logic [23:0] END_ADDRESS   = 24'd4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    core_interface_regs_if.slave        host,
    output logic [31:0]                 stream_o,
    output logic [32*TOTAL_INPUTS-1:0]  core_inputs_o,
    input  logic [32*TOTAL_OUTPUTS-1:0] core_outputs_i
);

    localparam int unsigned IN_W  = 32 * TOTAL_INPUTS;
    localparam int unsigned OUT_W = 32 * TOTAL_OUTPUTS;
    localparam logic [23:0] SPAN  = END_ADDRESS - START_ADDRESS;

    typedef enum logic [7:0] {
        OP_NOP    = 8'h00,
        OP_WRITE  = 8'h01,
        OP_READ   = 8'h02,
        OP_STREAM = 8'h03,
        OP_CLEAR  = 8'h04
    } opcode_e;

    // The subtraction is done one bit wider so a borrow flags addresses
    // below START_ADDRESS; there is no wrap-around into the window.
    function automatic logic window_hit(input logic [23:0] addr);
        logic [24:0] diff;
        diff = {1'b0, addr} - {1'b0, START_ADDRESS};
        return !diff[24] && (diff[23:0] <= SPAN);
    endfunction

    // Shared read mapping for READ and the stream mirror.
    function automatic logic [31:0] read_map(
        input logic [23:0]      addr,
        input logic [IN_W-1:0]  ins,
        input logic [OUT_W-1:0] outs
    );
        logic [23:0] idx;
        logic [31:0] val;
        val = '0;
        idx = addr - START_ADDRESS;
        if (window_hit(addr)) begin
            for (int unsigned k = 0; k < TOTAL_INPUTS; k++) begin
                if (idx == 24'(k)) val = ins[32*k +: 32];
            end
            for (int unsigned k = 0; k < TOTAL_OUTPUTS; k++) begin
                if (idx == 24'(TOTAL_INPUTS + k)) val = outs[32*k +: 32];
            end
        end
        return val;
    endfunction

    logic [IN_W-1:0]  in_q,     in_d;
    logic [OUT_W-1:0] out_q,    out_d;
    logic [31:0]      result_q, result_d;
    logic             hit;
    logic [23:0]      idx;

    assign hit = window_hit(host.address_i);
    assign idx = host.address_i - START_ADDRESS;

    always_comb begin
        in_d     = in_q;
        result_d = result_q;
        // Output registers sample the core unconditionally every cycle.
        out_d    = core_outputs_i;

        case (host.instruction_i)
            OP_WRITE: begin
                // Only input registers are writable; output and unmapped
                // indices fall through untouched.
                if (hit) begin
                    for (int unsigned k = 0; k < TOTAL_INPUTS; k++) begin
                        if (idx == 24'(k)) in_d[32*k +: 32] = host.value_i;
                    end
                end
            end
            OP_READ:  result_d = read_map(host.address_i, in_q, out_q);
            OP_CLEAR: in_d     = '0;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_q     <= '0;
            out_q    <= '0;
            result_q <= '0;
        end else begin
            in_q     <= in_d;
            out_q    <= out_d;
            result_q <= result_d;
        end
    end

    assign host.result_o = result_q;
    assign core_inputs_o = in_q;

`ifdef CORE_INTERFACE_STREAM_EN
    logic [23:0] ptr_q,    ptr_d;
    logic [31:0] stream_q, stream_d;

    always_comb begin
        ptr_d = ptr_q;
        if (host.instruction_i == OP_STREAM && hit) ptr_d = host.address_i;
        // Reads the registered state, so a new pointer or freshly written
        // register shows up one edge later than the instruction.
        stream_d = read_map(ptr_q, in_q, out_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q    <= START_ADDRESS;
            stream_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            stream_q <= stream_d;
        end
    end

    assign stream_o = stream_q;
`else
    assign stream_o = '0;
`endif

endmodule

// File: tb/tb_core_interface_regs.sv
// ----------------------------------------------------------------------------
// tb_core_interface_regs
//
// Directed bench for core_interface_regs with default parameters
// (4 inputs, 1 output, window 0..4). Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_core_interface_regs;

    localparam logic [7:0] NOP    = 8'h00;
    localparam logic [7:0] WRITE  = 8'h01;
    localparam logic [7:0] READ   = 8'h02;
    localparam logic [7:0] STREAM = 8'h03;
    localparam logic [7:0] CLEAR  = 8'h04;

`ifdef CORE_INTERFACE_STREAM_EN
    localparam bit STREAM_EN = 1'b1;
`else
    localparam bit STREAM_EN = 1'b0;
`endif

    logic          clk_i;
    logic          rst_ni;
    logic [31:0]   stream_o;
    logic [127:0]  core_inputs_o;
    logic [31:0]   core_outputs_i;

    int vectors;
    int miscompares;

    core_interface_regs_if bus ();

    core_interface_regs dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .host           (bus),
        .stream_o       (stream_o),
        .core_inputs_o  (core_inputs_o),
        .core_outputs_i (core_outputs_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step(input logic rst_n, input logic [7:0] op,
                        input logic [23:0] a, input logic [31:0] v);
        @(negedge clk_i);
        rst_ni            = rst_n;
        bus.instruction_i = op;
        bus.address_i     = a;
        bus.value_i       = v;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_ni         = 1'b0;
        core_outputs_i = 32'h0;
        bus.instruction_i = NOP;
        bus.address_i     = '0;
        bus.value_i       = '0;

        // Reset held two cycles while a WRITE is presented.
        step(1'b0, WRITE, 24'd0, 32'h0000_1234);
        step(1'b0, WRITE, 24'd0, 32'h0000_1234);
        chk32 ("rst_result", bus.result_o, 32'h0);
        chk32 ("rst_stream", stream_o, 32'h0);
        chk128("rst_inputs", core_inputs_o, 128'h0);

        // Write / read an input register.
        step(1'b1, WRITE, 24'd2, 32'hDEAD_BEEF);
        chk32 ("wr2_inputs_slice", core_inputs_o[95:64], 32'hDEAD_BEEF);
        step(1'b1, READ, 24'd2, 32'h0);
        chk32 ("rd2_result", bus.result_o, 32'hDEAD_BEEF);

        // NOP and an undefined opcode hold result_o.
        step(1'b1, NOP, 24'd0, 32'h0);
        step(1'b1, 8'h7F, 24'd1, 32'hFFFF_FFFF);
        chk32 ("nop_hold_result", bus.result_o, 32'hDEAD_BEEF);
        chk128("undef_op_inputs", core_inputs_o,
               128'h00000000_DEADBEEF_00000000_00000000);

        // Output register: captured one cycle, readable the next.
        core_outputs_i = 32'hCAFE_F00D;
        step(1'b1, NOP, 24'd0, 32'h0);
        step(1'b1, READ, 24'd4, 32'h0);
        chk32 ("rd4_result", bus.result_o, 32'hCAFE_F00D);
        step(1'b1, WRITE, 24'd4, 32'h0000_0001);
        step(1'b1, READ, 24'd4, 32'h0);
        chk32 ("wr4_ignored_result", bus.result_o, 32'hCAFE_F00D);

        // Out-of-window write ignored, read returns 0.
        step(1'b1, WRITE, 24'd5, 32'h0000_0055);
        step(1'b1, READ, 24'd5, 32'h0);
        chk32 ("rd5_result", bus.result_o, 32'h0);
        chk128("wr5_inputs", core_inputs_o,
               128'h00000000_DEADBEEF_00000000_00000000);

        // CLEAR wipes inputs only.
        step(1'b1, WRITE, 24'd0, 32'h1);
        step(1'b1, WRITE, 24'd1, 32'h2);
        step(1'b1, WRITE, 24'd2, 32'h3);
        step(1'b1, WRITE, 24'd3, 32'h4);
        chk128("wr0_3_inputs", core_inputs_o,
               128'h00000004_00000003_00000002_00000001);
        step(1'b1, CLEAR, 24'd0, 32'h0);
        chk128("clear_inputs", core_inputs_o, 128'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, WRITE, 24'd0, 32'h0);  // overwritten below
            step(1'b1, CLEAR, 24'd0, 32'h0);
            step(1'b1, READ, 24'(i), 32'h0);
            chk32 ("clear_rd", bus.result_o, 32'h0);
        end
        step(1'b1, READ, 24'd4, 32'h0);
        chk32 ("clear_keeps_output", bus.result_o, 32'hCAFE_F00D);

        // Write immediately followed by read of the same address.
        step(1'b1, WRITE, 24'd3, 32'h0000_0077);
        step(1'b1, READ, 24'd3, 32'h0);
        chk32 ("wr_then_rd3", bus.result_o, 32'h0000_0077);

        // Stream mirror. Pointer still at address 0 (reg0 = 0).
        step(1'b1, STREAM, 24'd1, 32'h0);
        chk32 ("strm_sel1_old", stream_o, 32'h0);
        step(1'b1, WRITE, 24'd1, 32'hA5A5_A5A5);
        chk32 ("strm_wr_edgeN", stream_o, 32'h0);
        step(1'b1, NOP, 24'd0, 32'h0);
        chk32 ("strm_wr_edgeN1", stream_o, STREAM_EN ? 32'hA5A5_A5A5 : 32'h0);
        step(1'b1, STREAM, 24'd9, 32'h0);
        step(1'b1, NOP, 24'd0, 32'h0);
        chk32 ("strm_oow_keeps_ptr", stream_o, STREAM_EN ? 32'hA5A5_A5A5 : 32'h0);
        step(1'b1, STREAM, 24'd4, 32'h0);
        step(1'b1, NOP, 24'd0, 32'h0);
        chk32 ("strm_sel4", stream_o, STREAM_EN ? 32'hCAFE_F00D : 32'h0);
        chk128("strm_inputs", core_inputs_o,
               128'h00000077_00000000_A5A5A5A5_00000000);

        // Core output change reaches stream_o two edges later.
        core_outputs_i = 32'h1234_5678;
        step(1'b1, NOP, 24'd0, 32'h0);
        chk32 ("strm_out_edgeN", stream_o, STREAM_EN ? 32'hCAFE_F00D : 32'h0);
        step(1'b1, NOP, 24'd0, 32'h0);
        chk32 ("strm_out_edgeN1", stream_o, STREAM_EN ? 32'h1234_5678 : 32'h0);

        // Reset mid-sequence discards the WRITE and clears everything.
        step(1'b0, WRITE, 24'd0, 32'h0000_0099);
        chk128("midrst_inputs", core_inputs_o, 128'h0);
        chk32 ("midrst_result", bus.result_o, 32'h0);
        chk32 ("midrst_stream", stream_o, 32'h0);
        // First cycle out of reset sees the cleared output register.
        step(1'b1, READ, 24'd4, 32'h0);
        chk32 ("post_rst_rd4_first", bus.result_o, 32'h0);
        step(1'b1, READ, 24'd4, 32'h0);
        chk32 ("post_rst_rd4_second", bus.result_o, 32'h1234_5678);
        // Stream pointer returned to START_ADDRESS (reg0).
        step(1'b1, WRITE, 24'd0, 32'h0000_0011);
        step(1'b1, NOP, 24'd0, 32'h0);
        chk32 ("post_rst_stream_ptr", stream_o, STREAM_EN ? 32'h0000_0011 : 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_interface_regs.md
# core_interface_regs

Memory-mapped register bridge between the host instruction bus and one user core. Each cycle the block decodes an 8-bit instruction against a 24-bit address window. It writes 32-bit values into core input registers and returns core input/output register contents on `result_o`. A continuously refreshed stream port mirrors one selected register.

## Interface
- `TOTAL_INPUTS`, default 4: number of 32-bit host-writable core input registers.
- `TOTAL_OUTPUTS`, default 1: number of 32-bit read-only core output registers.
- `START_ADDRESS`, default 0: first address of the window (24-bit).
- `END_ADDRESS`, default 4: last address of the window, inclusive (24-bit).

Ports:
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `instruction_i`  in  8  opcode, sampled every cycle.
- `address_i`  in  24  target address.
- `value_i`  in  32  write data.
- `result_o`  out  32  registered read result.
- `stream_o`  out  32  registered stream mirror.
- `core_inputs_o`  out  32*TOTAL_INPUTS  flattened input registers; register k is at bits [32k+31:32k].
- `core_outputs_i`  in  32*TOTAL_OUTPUTS  flattened core results, same packing.

## Operation
- Local index `idx = address_i - START_ADDRESS`. An address is in window iff `START_ADDRESS <= address_i <= END_ADDRESS`.
- Map:
  - idx 0..TOTAL_INPUTS-1 → input register idx.
  - idx TOTAL_INPUTS..TOTAL_INPUTS+TOTAL_OUTPUTS-1 → output register (idx-TOTAL_INPUTS).
  - Any other in-window idx is unmapped. It reads 0 and ignores writes.
- Output registers capture `core_outputs_i` every cycle.
- Opcodes:
  - 0x00 NOP: no state change; `result_o` holds.
  - 0x01 WRITE: if the address maps to an input register, that register is set to `value_i`. Otherwise ignored, including writes to output registers and out-of-window addresses.
  - 0x02 READ: `result_o` is set to the mapped register. Out-of-window or unmapped addresses give 0.
  - 0x03 STREAM: if the address is in window, the stream pointer is set to `address_i`. Otherwise the pointer is unchanged.
  - 0x04 CLEAR: all input registers are set to 0. Output registers are unaffected.
  - 0x05–0xFF: treated as NOP.
- Every cycle, `stream_o` is set to the register at the stream pointer, using the same read mapping as READ.
- Arithmetic: unsigned 24-bit compare and subtract. No wrap-around; addresses below START_ADDRESS are out of window.

## Timing
- Reset (`rst_ni`=0 at a clock edge):
  - all input and output registers, `result_o` and `stream_o` become 0;
  - the stream pointer becomes START_ADDRESS;
  - reset overrides any instruction in the same cycle.
- WRITE in cycle N: the new value appears on `core_inputs_o` after edge N.
- READ in cycle N: `result_o` is valid after edge N (1-cycle latency) and holds until the next READ or reset.
- WRITE then READ of the same address in cycle N+1: the read returns the new value.
- `core_outputs_i` change in cycle N:
  - visible to READ issued in cycle N+1;
  - appears on `stream_o` after edge N+1 (2-cycle path).
- `stream_o` tracking an input register reflects a WRITE in cycle N after edge N+1.
- STREAM in cycle N: `stream_o` shows the new target after edge N+1.
- Reset mid-sequence discards that cycle's instruction. Operation resumes on the first cycle with `rst_ni`=1.
- No handshake: every instruction completes in one cycle, and back-to-back instructions are always accepted.

## Configuration
- `CORE_INTERFACE_STREAM_EN` defined: the stream pointer, opcode 0x03 and `stream_o` behave as described above.
- Not defined:
  - `stream_o` is tied to constant 0;
  - 0x03 decodes as NOP;
  - the stream pointer is not implemented.

## Test plan
- Reset: hold `rst_ni`=0 for 2 cycles with WRITE 0x1234 to address 0 → `result_o`=0, `stream_o`=0, `core_inputs_o`=0.
- Write/read inputs: WRITE 0xDEADBEEF→addr 2, then READ addr 2 → `result_o`=0xDEADBEEF one cycle later; bits [95:64] of `core_inputs_o`=0xDEADBEEF.
- Output register: drive `core_outputs_i`=0xCAFEF00D, READ addr 4 → 0xCAFEF00D. WRITE 0x1→addr 4, then READ → still 0xCAFEF00D.
- Out of window: WRITE 0x55 to addr 5, then READ addr 5 → `result_o`=0; input registers unchanged.
- CLEAR: write 1, 2, 3, 4 to addr 0–3, issue 0x04, then READ addr 0–3 → all 0.
- Stream (macro defined): STREAM addr 1, then WRITE 0xA5A5A5A5→addr 1 → `stream_o`=0xA5A5A5A5 two edges after the WRITE. With the macro undefined → `stream_o`=0 throughout.
